// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
//
// Memory-side responder for the cache RAM interface. Serves line-refill reads
// (single word or full-line burst) after a programmable latency, and absorbs
// dirty-line writebacks into an internal word-addressed SRAM array.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   ar/araddr/arsize      read request; rready = request accepted when ar high
//   rvalid/rlast/rdata    read response beats (no backpressure)
//   aw/awaddr/awsize      write request; accepted in IDLE (wready high)
//   wdata/awstrb/wvalid   write data beats with byte enables
//   wready                high in IDLE (address phase) and WR_DATA (data phase)
//   bvalid                one-cycle pulse when a write transaction commits
//
// Size encoding: 3'b100 = full-line burst of LINE_WORDS beats, all else 1 beat.
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   defined   - read bursts begin at the requested word and wrap in the line
//   undefined - read bursts always begin at word 0 of the line
// -----------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int MEM_AW     = 12,
    parameter int LINE_WORDS = 4,
    parameter int RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ar,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    output logic        rready,
    output logic        rvalid,
    output logic        rlast,
    output logic [31:0] rdata,
    input  logic        aw,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic [3:0]  awstrb,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid
);

    localparam int          OFF_W     = $clog2(LINE_WORDS);
    localparam int          CNT_W     = OFF_W + 1;
    localparam logic [2:0]  SIZE_LINE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [MEM_AW-1:0]   r_base;     // first word; low bits hold the wrap start
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_beat;
    logic [3:0]          r_lat;
    logic                r_rlast;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [0:(1<<MEM_AW)-1];

    logic [MEM_AW-1:0]   w_ar_word;
    logic [MEM_AW-1:0]   w_aw_word;
    logic [MEM_AW-1:0]   w_ar_line_base;
    logic [MEM_AW-1:0]   w_ar_base;
    logic [MEM_AW-1:0]   w_aw_base;
    logic [CNT_W-1:0]    w_ar_count;
    logic [CNT_W-1:0]    w_aw_count;
    logic [OFF_W-1:0]    w_off;
    logic [MEM_AW-1:0]   w_idx;
    logic                w_last_beat;
    logic                w_mem_we;
    logic                w_unused;

    // Upper address bits alias; byte offset is ignored (word-aligned data).
    assign w_ar_word = araddr[MEM_AW+1:2];
    assign w_aw_word = awaddr[MEM_AW+1:2];
    assign w_unused  = &{1'b0, araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

`ifdef CRITICAL_WORD_FIRST_EN
    // Keep the requested word offset so the burst wraps around it.
    assign w_ar_line_base = w_ar_word;
`else
    assign w_ar_line_base = {w_ar_word[MEM_AW-1:OFF_W], {OFF_W{1'b0}}};
`endif

    assign w_ar_base  = (arsize == SIZE_LINE) ? w_ar_line_base : w_ar_word;
    assign w_aw_base  = (awsize == SIZE_LINE)
                      ? {w_aw_word[MEM_AW-1:OFF_W], {OFF_W{1'b0}}} : w_aw_word;
    assign w_ar_count = (arsize == SIZE_LINE) ? CNT_W'(LINE_WORDS) : CNT_W'(1);
    assign w_aw_count = (awsize == SIZE_LINE) ? CNT_W'(LINE_WORDS) : CNT_W'(1);

    // Beat offset wraps modulo LINE_WORDS inside the line; single beats use
    // beat 0 so the exact word is addressed.
    assign w_off       = r_base[OFF_W-1:0] + r_beat[OFF_W-1:0];
    assign w_idx       = {r_base[MEM_AW-1:OFF_W], w_off};
    assign w_last_beat = (r_beat == r_count - CNT_W'(1));

    assign rlast = r_rlast;
    assign rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_next   = r_state;
        rready   = 1'b0;
        wready   = 1'b0;
        rvalid   = 1'b0;
        bvalid   = 1'b0;
        w_mem_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                wready = 1'b1;
                // Writeback wins a collision; the read stays pending.
                rready = ~aw;
                if (aw) begin
                    w_next = S_WR_DATA;
                end else if (ar) begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_lat == 4'd0) begin
                    w_next = S_RD_BURST;
                end
            end
            S_RD_BURST: begin
                rvalid = 1'b1;
                if (r_rlast) begin
                    w_next = S_IDLE;
                end
            end
            S_WR_DATA: begin
                wready   = 1'b1;
                w_mem_we = wvalid & resetn;
                if (wvalid && w_last_beat) begin
                    w_next = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bvalid = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_base  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_rlast <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (aw) begin
                        r_base  <= w_aw_base;
                        r_count <= w_aw_count;
                        r_beat  <= '0;
                    end else if (ar) begin
                        r_base  <= w_ar_base;
                        r_count <= w_ar_count;
                        r_beat  <= '0;
                        r_lat   <= 4'(RD_LAT - 1);
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat != 4'd0) begin
                        r_lat <= r_lat - 4'd1;
                    end else begin
                        // First beat is registered on the same edge that
                        // enters RD_BURST, giving exactly RD_LAT cycles.
                        r_rdata <= r_mem[w_idx];
                        r_rlast <= w_last_beat;
                        r_beat  <= r_beat + CNT_W'(1);
                    end
                end
                S_RD_BURST: begin
                    if (r_rlast) begin
                        r_rlast <= 1'b0;
                    end else begin
                        r_rdata <= r_mem[w_idx];
                        r_rlast <= w_last_beat;
                        r_beat  <= r_beat + CNT_W'(1);
                    end
                end
                S_WR_DATA: begin
                    if (wvalid) begin
                        r_beat <= r_beat + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the SRAM array has no reset; contents survive resetn so a
    // partially written line keeps the beats that already landed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (awstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;

    localparam int MEM_AW = 12;
    localparam int LINE   = 4;
    localparam int RD_LAT = 2;
    localparam int NWORDS = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ar;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rready;
    logic        rvalid;
    logic        rlast;
    logic [31:0] rdata;
    logic        aw;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [3:0]  awstrb;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        bvalid;

    cache_mem_responder #(
        .MEM_AW    (MEM_AW),
        .LINE_WORDS(LINE),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .ar    (ar),
        .araddr(araddr),
        .arsize(arsize),
        .rready(rready),
        .rvalid(rvalid),
        .rlast (rlast),
        .rdata (rdata),
        .aw    (aw),
        .awaddr(awaddr),
        .awsize(awsize),
        .awstrb(awstrb),
        .wdata (wdata),
        .wvalid(wvalid),
        .wready(wready),
        .bvalid(bvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flat word array indexed by the aliased word address.
    logic [31:0] mdl [0:NWORDS-1];

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } rexp_t;

    rexp_t rq[$];      // expected read beats with their cycle
    int    bq[$];      // expected bvalid cycles

    logic [31:0] wd_buf [0:LINE-1];
    logic [3:0]  ws_buf [0:LINE-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[MEM_AW+1:2]);
    endfunction

    function automatic int nbeats(input logic [2:0] s);
        return (s == 3'b100) ? LINE : 1;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a response.
    rexp_t mon_e;
    int    mon_b;
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid === 1'b1) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", rvalid, 0);
                end else begin
                    mon_e = rq.pop_front();
                    check("rdata", rdata, mon_e.data);
                    check("rlast", rlast, mon_e.last);
                    check("rbeat_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check("rlast_without_rvalid", rlast, 0);
                if (rq.size() != 0 && cyc >= rq[0].cyc) begin
                    check("rvalid_missing", rvalid, 1);
                    void'(rq.pop_front());
                end
            end
            if (bvalid === 1'b1) begin
                if (bq.size() == 0) begin
                    check("bvalid_unexpected", bvalid, 0);
                end else begin
                    mon_b = bq.pop_front();
                    check("bvalid_cycle", cyc, mon_b);
                end
            end else if (bq.size() != 0 && cyc >= bq[0]) begin
                check("bvalid_missing", bvalid, 1);
                void'(bq.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int t;
        for (t = 0; t < 500; t++) begin
            if (rq.size() == 0 && bq.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (t == 500) check("idle_timeout", rq.size() + bq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ar must already be driven; waits for acceptance, queues expected beats.
    task automatic read_accept(input logic [31:0] a, input logic [2:0] s);
        int t, n, w0, lb, st, w, c;
        rexp_t e;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rready === 1'b1) break;
        end
        if (t == 200) begin
            check("rready_timeout", rready, 1);
            ar = 1'b0;
            return;
        end
        c  = cyc;
        n  = nbeats(s);
        w0 = widx(a);
        lb = w0 & ~(LINE - 1);
`ifdef CRITICAL_WORD_FIRST_EN
        st = w0 % LINE;
`else
        st = 0;
`endif
        for (int i = 0; i < n; i++) begin
            w      = (n == 1) ? w0 : lb + ((st + i) % LINE);
            e.data = mdl[w];
            e.last = (i == n - 1);
            e.cyc  = c + 1 + RD_LAT + i;
            rq.push_back(e);
        end
        @(posedge clk);
        #1;
        ar = 1'b0;
        @(negedge clk);
        check("rready_busy", rready, 0);
        check("wready_busy", wready, 0);
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [2:0] s);
        wait_idle();
        ar     = 1'b1;
        araddr = a;
        arsize = s;
        read_accept(a, s);
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [2:0] s,
                             input int stall_at, input int stall_len,
                             input int abort_after, input bit collide,
                             input logic [31:0] ra, input logic [2:0] rs);
        int n, w0, lb, w;
        wait_idle();
        aw     = 1'b1;
        awaddr = a;
        awsize = s;
        if (collide) begin
            ar     = 1'b1;
            araddr = ra;
            arsize = rs;
        end
        @(negedge clk);
        check("wready_idle", wready, 1);
        check("rready_with_aw", rready, 0);
        @(posedge clk);
        #1;
        aw = 1'b0;
        n  = nbeats(s);
        w0 = widx(a);
        lb = w0 & ~(LINE - 1);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                repeat (stall_len) begin
                    wdata  = $urandom;
                    awstrb = 4'hF;
                    @(posedge clk);
                    #1;
                end
            end
            wvalid = 1'b1;
            wdata  = wd_buf[i];
            awstrb = ws_buf[i];
            w = (n == 1) ? w0 : lb + i;
            for (int b = 0; b < 4; b++) begin
                if (ws_buf[i][b]) mdl[w][8*b +: 8] = wd_buf[i][8*b +: 8];
            end
            if (i == n - 1) bq.push_back(cyc + 1);
            @(posedge clk);
            #1;
            wvalid = 1'b0;
            if (abort_after == i + 1) begin
                resetn = 1'b0;
                @(posedge clk);
                #1;
                resetn = 1'b1;
                @(negedge clk);
                check("wready_after_abort", wready, 1);
                check("bvalid_after_abort", bvalid, 0);
                return;
            end
        end
        if (collide) read_accept(ra, rs);
    endtask

    task automatic reset_during_read(input logic [31:0] a);
        int t;
        read_txn(a, 3'b100);
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rvalid === 1'b1) break;
        end
        if (t == 50) check("rvalid_timeout", rvalid, 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        rq.delete();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_rlast", rlast, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_rready", rready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  s;
        resetn = 1'b0;
        ar = 1'b0; araddr = '0; arsize = '0;
        aw = 1'b0; awaddr = '0; awsize = '0;
        awstrb = '0; wdata = '0; wvalid = 1'b0;

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("idle_rready", rready, 1);
        check("idle_wready", wready, 1);

        // Fill words 0..255 so every later read hits known data.
        for (int l = 0; l < 256 / LINE; l++) begin
            for (int i = 0; i < LINE; i++) begin
                wd_buf[i] = $urandom;
                ws_buf[i] = 4'hF;
            end
            write_txn(32'(l * LINE * 4), 3'b100, -1, 0, 0, 1'b0, '0, '0);
        end

        // Writeback burst then line read.
        for (int i = 0; i < LINE; i++) begin
            wd_buf[i] = 32'h11 * (i + 1);
            ws_buf[i] = 4'hF;
        end
        write_txn(32'h100, 3'b100, -1, 0, 0, 1'b0, '0, '0);
        read_txn(32'h100, 3'b100);

        // Critical-word read (order depends on the build option).
        read_txn(32'h108, 3'b100);

        // Byte strobe single write.
        wd_buf[0] = 32'hAABBCCDD;
        ws_buf[0] = 4'b0101;
        write_txn(32'h104, 3'b010, -1, 0, 0, 1'b0, '0, '0);
        read_txn(32'h104, 3'b010);

        // Zero strobe: beat consumed, nothing written.
        wd_buf[0] = 32'hDEADBEEF;
        ws_buf[0] = 4'b0000;
        write_txn(32'h10C, 3'b000, -1, 0, 0, 1'b0, '0, '0);
        read_txn(32'h10C, 3'b001);

        // Collision: write wins, read follows and sees the new line.
        for (int i = 0; i < LINE; i++) begin
            wd_buf[i] = $urandom;
            ws_buf[i] = 4'hF;
        end
        write_txn(32'h200, 3'b100, -1, 0, 0, 1'b1, 32'h208, 3'b100);

        // wvalid stall of two cycles between beats 1 and 2.
        for (int i = 0; i < LINE; i++) begin
            wd_buf[i] = $urandom;
            ws_buf[i] = 4'hF;
        end
        write_txn(32'h300, 3'b100, 2, 2, 0, 1'b0, '0, '0);
        read_txn(32'h300, 3'b100);

        // Aliased upper address bits.
        read_txn(32'hFFFF_C300, 3'b100);

        // Reset mid read burst, then reset mid writeback.
        reset_during_read(32'h000);
        for (int i = 0; i < LINE; i++) begin
            wd_buf[i] = $urandom;
            ws_buf[i] = 4'hF;
        end
        write_txn(32'h040, 3'b100, -1, 0, 2, 1'b0, '0, '0);
        read_txn(32'h040, 3'b100);

        // Randomised traffic inside the filled region.
        for (int k = 0; k < 80; k++) begin
            a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255) << 2)
              | 32'($urandom_range(0, 3));
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) s = 3'b100;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < LINE; i++) begin
                    wd_buf[i] = $urandom;
                    ws_buf[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                end
                write_txn(a, s, $urandom_range(0, LINE), $urandom_range(0, 3),
                          0, 1'b0, '0, '0);
            end else begin
                read_txn(a, s);
            end
        end

        wait_idle();
        check("rq_drained", rq.size(), 0);
        check("bq_drained", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
